// File: rtl/dpc_pkg.sv
// dpc_pkg: shared types and arithmetic for the DPC row corrector.
package dpc_pkg;

    typedef enum logic [1:0] {EMPTY, HOLD, FLUSH_LAST} state_t;

    // Flag/valid/SOF tag of a window entry; the pixel data sits beside it
    // because its width is a module parameter.
    typedef struct packed {
        logic flag;
        logic valid;
        logic sof;
    } win_t;

    localparam int AVG_W = 32;

    function automatic logic [AVG_W-1:0] round_avg(input logic [AVG_W-1:0] a, input logic [AVG_W-1:0] b);
        return AVG_W'(({1'b0, a} + {1'b0, b} + (AVG_W+1)'(1)) >> 1);
    endfunction

endpackage

// File: rtl/dpc_interp_sel.sv
// dpc_interp_sel: picks the replacement for a flagged centre pixel from its horizontal neighbours.
// With DPC_STATS_EN it also reports whether the centre was actually replaced.
module dpc_interp_sel
    import dpc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             en_i,
    input  logic             l_valid_i,
    input  logic             l_flag_i,
    input  logic [WIDTH-1:0] l_data_i,
    input  logic             c_flag_i,
    input  logic [WIDTH-1:0] c_data_i,
    input  logic             r_valid_i,
    input  logic             r_flag_i,
    input  logic [WIDTH-1:0] r_data_i,
    input  logic [WIDTH-1:0] last_data_i,
`ifdef DPC_STATS_EN
    output logic             replaced_o,
`endif
    output logic [WIDTH-1:0] data_o
);

    logic             l_ok, r_ok, hit;
    logic [WIDTH-1:0] avg, fix;

    assign l_ok = l_valid_i && !l_flag_i;
    assign r_ok = r_valid_i && !r_flag_i;
    assign hit  = en_i && c_flag_i;
    assign avg  = WIDTH'(round_avg(AVG_W'(l_data_i), AVG_W'(r_data_i)));
    // With no good neighbour, reuse the previous output of the row; a row's first pixel stays as is.
    assign fix  = (l_ok && r_ok) ? avg :
                  l_ok           ? l_data_i :
                  r_ok           ? r_data_i :
                  l_valid_i      ? last_data_i : c_data_i;
    assign data_o = hit ? fix : c_data_i;

`ifdef DPC_STATS_EN
    assign replaced_o = hit && (l_ok || r_ok || l_valid_i);
`endif

endmodule

// File: rtl/dpc_row_corrector.sv
// dpc_row_corrector: replaces flagged pixels with an interpolation of valid horizontal neighbours.
// AXI4-Stream in/out, one pixel lookahead; DPC_STATS_EN adds the per-frame corrected_count output.
module dpc_row_corrector
    import dpc_pkg::*;
#(
`ifdef DPC_STATS_EN
    parameter int CNT_WIDTH = 10,
`endif
    parameter int WIDTH = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 enable,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [WIDTH-1:0]     s_axis_tdata,
    input  logic                 s_axis_tuser,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tflag,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [WIDTH-1:0]     m_axis_tdata,
    output logic                 m_axis_tuser,
    output logic                 m_axis_tlast,
`ifdef DPC_STATS_EN
    output logic [CNT_WIDTH-1:0] corrected_count,
`endif
    output logic                 frame_done
);

    state_t           state_q, state_d;
    win_t             c_q, c_d, r_in;
    logic             l_valid_q, l_valid_d, l_flag_q, l_flag_d;
    logic [WIDTH-1:0] l_data_q, l_data_d, c_data_q, c_data_d, m_data_q, m_data_d, sel_data;
    logic             en_q, en_d, pend_q, pend_d;
    logic             m_valid_q, m_valid_d, m_user_q, m_user_d, m_last_q, m_last_d;
    logic             flush, slot, s_acc, sof_acc, eol_acc, emit;
`ifdef DPC_STATS_EN
    logic             replaced;
`endif

    assign flush         = state_q == FLUSH_LAST;
    assign slot          = !m_valid_q || m_axis_tready;
    assign s_axis_tready = !flush && slot;
    assign s_acc         = s_axis_tvalid && s_axis_tready;
    assign sof_acc       = s_acc && s_axis_tuser;
    assign eol_acc       = m_valid_q && m_axis_tready && m_last_q;
    // C is only valid in HOLD/FLUSH_LAST, so this covers both emitting states.
    assign emit          = flush ? slot : (c_q.valid && s_acc);
    assign r_in          = '{flag: s_axis_tflag, valid: !flush && !s_axis_tuser, sof: s_axis_tuser};
    // An EOL only ends a frame once the following SOF shows up.
    assign frame_done    = sof_acc && (pend_q || eol_acc);

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tuser  = m_user_q;
    assign m_axis_tlast  = m_last_q;

    dpc_interp_sel #(.WIDTH(WIDTH)) u_sel (
        .en_i        (en_q),
        .l_valid_i   (l_valid_q),
        .l_flag_i    (l_flag_q),
        .l_data_i    (l_data_q),
        .c_flag_i    (c_q.flag),
        .c_data_i    (c_data_q),
        .r_valid_i   (r_in.valid),
        .r_flag_i    (r_in.flag),
        .r_data_i    (s_axis_tdata),
        .last_data_i (m_data_q),
`ifdef DPC_STATS_EN
        .replaced_o  (replaced),
`endif
        .data_o      (sel_data)
    );

    always_comb begin
        state_d   = state_q;
        l_valid_d = l_valid_q;
        l_flag_d  = l_flag_q;
        l_data_d  = l_data_q;
        c_d       = c_q;
        c_data_d  = c_data_q;
        en_d      = sof_acc ? enable : en_q;
        pend_d    = s_acc ? 1'b0 : eol_acc ? 1'b1 : pend_q;
        m_valid_d = emit || (m_valid_q && !m_axis_tready);
        m_data_d  = emit ? sel_data : m_data_q;
        m_user_d  = emit ? c_q.sof : m_user_q;
        m_last_d  = emit ? flush : m_last_q;
        case (state_q)
            EMPTY, HOLD: if (s_acc) begin
                l_valid_d = c_q.valid && !s_axis_tuser;
                l_flag_d  = c_q.flag;
                l_data_d  = c_data_q;
                c_d       = '{flag: r_in.flag, valid: 1'b1, sof: r_in.sof};
                c_data_d  = s_axis_tdata;
                state_d   = s_axis_tlast ? FLUSH_LAST : HOLD;
            end
            FLUSH_LAST: if (slot) begin
                l_valid_d = 1'b0;
                c_d       = '0;
                state_d   = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= EMPTY;
            l_valid_q <= 1'b0;
            l_flag_q  <= 1'b0;
            l_data_q  <= '0;
            c_q       <= '0;
            c_data_q  <= '0;
            en_q      <= 1'b0;
            pend_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_user_q  <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            l_valid_q <= l_valid_d;
            l_flag_q  <= l_flag_d;
            l_data_q  <= l_data_d;
            c_q       <= c_d;
            c_data_q  <= c_data_d;
            en_q      <= en_d;
            pend_q    <= pend_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_user_q  <= m_user_d;
            m_last_q  <= m_last_d;
        end
    end

`ifdef DPC_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, count_q, count_d;

    // Restart on the emitted SOF beat, which may itself be a replaced pixel.
    always_comb begin
        cnt_d   = (emit && c_q.sof)                  ? CNT_WIDTH'(replaced) :
                  (emit && replaced && !(&cnt_q))    ? cnt_q + CNT_WIDTH'(1) : cnt_q;
        count_d = frame_done ? cnt_q : count_q;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q   <= '0;
            count_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            count_q <= count_d;
        end
    end

    assign corrected_count = count_q;
`endif

endmodule
